mdu_iter_core: RTL and testbench
================================

Name: mdu_iter_core

Overview:
Multi-cycle iterative arithmetic engine for MULT/MULTU/DIV/DIVU, sitting directly behind the MDU. The MDU hands it operands with a start pulse, tracks its busy flag for the stall logic, and commits the returned hi/lo into HI/LO. It uses a radix-2 shift-add multiplier and a restoring divider on operand magnitudes, followed by sign correction. The latency is fixed for every operation.

Parameters:
WIDTH, 32, operand width. Only 32 is used in the CPU. Results are 2*WIDTH bits, split into hi and lo.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset (reset==0 at a clk edge resets)
start  in  1  request; sampled only in IDLE or in the done cycle
op  in  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU
a  in  WIDTH  rs operand (multiplicand / dividend)
b  in  WIDTH  rt operand (multiplier / divisor)
flush  in  1  abort the in-flight operation (exception/cancel)
busy  out  1  operation in flight
done  out  1  one-cycle pulse; hi/lo are valid and new
hi  out  WIDTH  product[63:32] or remainder
lo  out  WIDTH  product[31:0] or quotient

Behaviour:
- Reset (reset==0 at edge): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset has priority over flush and start, and applies mid-operation.
- States are IDLE, CALC and FIN. busy = (state != IDLE). done is a registered pulse.
- Edge E0, in IDLE with start=1:
  - Latch op, the sign bits of a and b, |a| and |b|. Magnitude is taken only for signed ops; unsigned ops use the raw values.
  - Latch divzero = (b==0) && op is DIV/DIVU.
  - Clear the accumulator; counter=0; go to CALC.
- CALC, edges E1..E32, one iteration per edge:
  - Multiply: when the multiplier LSB is 1, add the multiplicand into the upper half; then shift the 64-bit {acc,multiplier} register right by 1, capturing the carry.
  - Divide (restoring): shift {rem,quot} left by 1. If rem >= divisor, rem -= divisor and set quot LSB.
  - counter increments each edge. Going from counter==31 moves to FIN.
- FIN, edge E33:
  - Apply sign fix for signed ops:
    - product is negated (64-bit two's complement) when sign_a^sign_b;
    - quotient is negated when sign_a^sign_b;
    - remainder is negated when sign_a.
  - If divzero: hi=a as latched (original value, not magnitude), lo=all ones, regardless of signedness.
  - Write hi/lo, done<=1, state<=IDLE.
- Latency: done is high in the cycle after E33, i.e. 33 cycles after the accepting edge. busy is high after E0 through E33. busy and done never overlap.
- done drops on the following edge unless a new completion occurs.
- Back-to-back: start in the done cycle (state is IDLE) is accepted.
- start while busy is ignored, with no queuing.
- hi/lo hold their value until the next FIN. They are never modified during CALC.
- flush=1 at an edge while busy: go to IDLE with no done, hi/lo unchanged. Flush beats start in the same edge. Flush in IDLE has no effect.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, with no special handling.
- All arithmetic is modulo 2^64 (products) or 2^32 (div results). The subtract compare is WIDTH+1 bits.

Decomposition:
- Shared header (macro include) holds:
  - the op encodings, as 2-bit defines MDUC_MULT/MULTU/DIV/DIVU;
  - the state encodings S_IDLE/S_CALC/S_FIN;
  - the iteration count ITER=32.
- One natural sub-module: mdu_sign_fix. It is combinational and produces the final {hi,lo} from the raw result, sign_a, sign_b, op and divzero.
- Everything else stays in mdu_iter_core.

Test Plan:
1. MULT a=0xFFFFFFFE b=3 -> done exactly 33 cycles after the start edge; hi=0xFFFFFFFF lo=0xFFFFFFFA; busy high 33 cycles.
2. MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001. Back-to-back MULT 7*6 issued in the done cycle -> hi=0 lo=42, 33 cycles later.
3. DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF. DIVU 7/2 -> lo=3 hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
4. Divide by zero: DIVU 5/0 -> hi=5 lo=0xFFFFFFFF. DIV 0xFFFFFFF9/0 -> hi=0xFFFFFFF9 lo=0xFFFFFFFF.
5. Start MULT 3*4; pulse start with DIV 9/3 at cycle 5; assert flush at cycle 10 -> second start ignored, no done, busy=0 after the flush edge, hi/lo keep prior values. A following DIVU 9/3 -> lo=3 hi=0.
6. Drive reset=0 for one edge at cycle 20 of a MULT -> busy=0, done=0, hi=lo=0. Start with reset=0 -> not accepted.

Source files
------------

// File: rtl/mdu_iter_core_pkg.sv
// mdu_iter_core_pkg: op/state encodings and iteration count shared by the MDU iterative core.  rev 1.0
`default_nettype none

package mdu_iter_core_pkg;

  localparam logic [1:0] MDUC_MULT  = 2'd0;
  localparam logic [1:0] MDUC_MULTU = 2'd1;
  localparam logic [1:0] MDUC_DIV   = 2'd2;
  localparam logic [1:0] MDUC_DIVU  = 2'd3;

  localparam int ITER = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_iter_core_sign_fix.sv
// mdu_sign_fix: converts the raw magnitude result into final hi/lo (sign fix, divide-by-zero).  rev 1.0
`default_nettype none

module mdu_sign_fix
  import mdu_iter_core_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] raw_hi,
  input  logic [WIDTH-1:0] raw_lo,
  input  logic [WIDTH-1:0] a_orig,
  input  logic [1:0]       op,
  input  logic             sign_a,
  input  logic             sign_b,
  input  logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [2*WIDTH-1:0] prod_neg;

  assign prod_neg = ~{raw_hi, raw_lo} + 1'b1;

  always_comb begin
    hi = raw_hi;
    lo = raw_lo;
    if (divzero) begin
      hi = a_orig;
      lo = '1;
    end else if (op == MDUC_MULT) begin
      if (sign_a ^ sign_b) begin
        {hi, lo} = prod_neg;
      end
    end else if (op == MDUC_DIV) begin
      // remainder follows the dividend, quotient follows the sign difference
      if (sign_a ^ sign_b) begin
        lo = ~raw_lo + 1'b1;
      end
      if (sign_a) begin
        hi = ~raw_hi + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: fixed-latency radix-2 shift-add multiplier / restoring divider for MULT/DIV.  rev 1.0
`default_nettype none

module mdu_iter_core
  import mdu_iter_core_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(ITER) + 1;

  state_t state, state_next;

  logic [1:0]       op_q;
  logic             sign_a, sign_b, divzero;
  logic [WIDTH-1:0] a_orig;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] acc, shreg;
  logic [WIDTH-1:0] acc_next, shreg_next;
  logic [CNT_W-1:0] counter;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] fix_hi, fix_lo;

  assign busy = (state != S_IDLE);

  assign mag_a = (op_is_signed(op) && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign mag_b = (op_is_signed(op) && b[WIDTH-1]) ? (~b + 1'b1) : b;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_CALC;
      S_CALC: begin
        if (flush) begin
          state_next = S_IDLE;
        end else if (counter == CNT_W'(ITER - 1)) begin
          state_next = S_FIN;
        end
      end
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // {acc, shreg} is {product_hi, multiplier} for multiply and {remainder, quotient} for divide
  always_comb begin
    mul_sum    = {1'b0, acc} + (shreg[0] ? {1'b0, operand} : '0);
    div_shift  = {acc, shreg[WIDTH-1]};
    div_ge     = (div_shift >= {1'b0, operand});
    acc_next   = mul_sum[WIDTH:1];
    shreg_next = {mul_sum[0], shreg[WIDTH-1:1]};
    if (op_is_div(op_q)) begin
      if (div_ge) begin
        acc_next = WIDTH'(div_shift - {1'b0, operand});
      end else begin
        acc_next = div_shift[WIDTH-1:0];
      end
      shreg_next = {shreg[WIDTH-2:0], div_ge};
    end
  end

  mdu_sign_fix #(
    .WIDTH (WIDTH)
  ) u_sign_fix (
    .raw_hi  (acc),
    .raw_lo  (shreg),
    .a_orig  (a_orig),
    .op      (op_q),
    .sign_a  (sign_a),
    .sign_b  (sign_b),
    .divzero (divzero),
    .hi      (fix_hi),
    .lo      (fix_lo)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q    <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      divzero <= 1'b0;
      a_orig  <= '0;
      operand <= '0;
      acc     <= '0;
      shreg   <= '0;
      counter <= '0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q    <= op;
            sign_a  <= a[WIDTH-1];
            sign_b  <= b[WIDTH-1];
            divzero <= (b == '0) && op_is_div(op);
            a_orig  <= a;
            operand <= op_is_div(op) ? mag_b : mag_a;
            shreg   <= op_is_div(op) ? mag_a : mag_b;
            acc     <= '0;
            counter <= '0;
          end
        end
        S_CALC: begin
          acc     <= acc_next;
          shreg   <= shreg_next;
          counter <= counter + 1'b1;
        end
        S_FIN: begin
          if (!flush) begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mdu_iter_core.sv
// tb_mdu_iter_core: scoreboard bench for mdu_iter_core (latency, arithmetic, flush, reset).  rev 1.0
`default_nettype none

module tb_mdu_iter_core;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op    = 2'd0;
  logic [31:0] a     = 32'd0;
  logic [31:0] b     = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb_q[$];

  mdu_iter_core #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = $signed(x);
    sy = $signed(y);
    res = '0;
    case (o)
      OP_MULT:  res = sx * sy;
      OP_MULTU: res = {32'd0, x} * {32'd0, y};
      OP_DIV: begin
        if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
        else res = {x % y, x / y};
      end
    endcase
    return res;
  endfunction

  // Called #1 after a posedge; returns #1 after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic push, input logic [63:0] exp_val);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    if (push) sb_q.push_back(exp_val);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int busy_cyc, output int overlap, output logic [63:0] res);
    cyc = 0;
    busy_cyc = busy ? 1 : 0;
    overlap = 0;
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy && done) overlap++;
      if (done) break;
      if (busy) busy_cyc++;
    end
    res = {hi, lo};
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); end
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mult();
    int cyc, bc, ov;
    logic [63:0] res, exp_v, held;
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA);
    wait_done(cyc, bc, ov, res);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL mult_latency: got %0d expected 33", cyc); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL mult_busy_cycles: got %0d expected 33", bc); end
    checks++; if (ov !== 0) begin errors++; $display("FAIL mult_busy_done_overlap: got %0d expected 0", ov); end
    exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    checks++; if (res !== exp_v) begin errors++; $display("FAIL mult_result: got %h expected %h", res, exp_v); end
    held = res;
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b expected 0", done); end
    checks++; if ({hi, lo} !== held) begin errors++; $display("FAIL hilo_hold: got %h expected %h", {hi, lo}, held); end
  endtask

  task automatic test_back_to_back();
    int cyc, bc, ov;
    logic [63:0] res, exp_v;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
    wait_done(cyc, bc, ov, res);
    exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    checks++; if (res !== exp_v) begin errors++; $display("FAIL multu_result: got %h expected %h", res, exp_v); end
    // issued in the done cycle
    issue(OP_MULT, 32'd7, 32'd6, 1'b1, 64'd42);
    wait_done(cyc, bc, ov, res);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL b2b_latency: got %0d expected 33", cyc); end
    exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    checks++; if (res !== exp_v) begin errors++; $display("FAIL b2b_result: got %h expected %h", res, exp_v); end
  endtask

  task automatic test_div();
    int cyc, bc, ov;
    logic [63:0] res, exp_v;
    logic [1:0]  ops[3]  = '{OP_DIV, OP_DIVU, OP_DIV};
    logic [31:0] as[3]   = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
    logic [31:0] bs[3]   = '{32'd2, 32'd2, 32'hFFFF_FFFF};
    logic [63:0] exps[3] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0001_0000_0003, 64'h0000_0000_8000_0000};
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], bs[i], 1'b1, exps[i]);
      wait_done(cyc, bc, ov, res);
      exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
      checks++; if (res !== exp_v) begin errors++; $display("FAIL div_result_%0d: got %h expected %h", i, res, exp_v); end
    end
  endtask

  task automatic test_divzero();
    int cyc, bc, ov;
    logic [63:0] res, exp_v;
    issue(OP_DIVU, 32'd5, 32'd0, 1'b1, 64'h0000_0005_FFFF_FFFF);
    wait_done(cyc, bc, ov, res);
    exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    checks++; if (res !== exp_v) begin errors++; $display("FAIL divu_zero: got %h expected %h", res, exp_v); end
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd0, 1'b1, 64'hFFFF_FFF9_FFFF_FFFF);
    wait_done(cyc, bc, ov, res);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL divzero_latency: got %0d expected 33", cyc); end
    exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    checks++; if (res !== exp_v) begin errors++; $display("FAIL div_zero: got %h expected %h", res, exp_v); end
  endtask

  task automatic test_flush();
    int cyc, bc, ov, seen;
    logic [63:0] res, exp_v, prior;
    prior = {hi, lo};
    issue(OP_MULT, 32'd3, 32'd4, 1'b0, 64'd0);
    repeat (4) @(posedge clk);
    #1;
    op = OP_DIV; a = 32'd9; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_done: got %b expected 0", done); end
    checks++; if ({hi, lo} !== prior) begin errors++; $display("FAIL flush_hilo: got %h expected %h", {hi, lo}, prior); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_activity: got %0d active cycles expected 0", seen); end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++; if ({busy, done, hi, lo} !== {2'b00, prior}) begin
      errors++; $display("FAIL idle_flush: got %b%b %h expected 00 %h", busy, done, {hi, lo}, prior);
    end
    issue(OP_DIVU, 32'd9, 32'd3, 1'b1, 64'd3);
    wait_done(cyc, bc, ov, res);
    exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    checks++; if (res !== exp_v) begin errors++; $display("FAIL post_flush_divu: got %h expected %h", res, exp_v); end
  endtask

  task automatic test_reset_mid();
    int seen;
    issue(OP_MULT, 32'd5, 32'd5, 1'b0, 64'd0);
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL midreset_flags: got %b expected 00", {busy, done}); end
    checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL midreset_hilo: got %h expected 0", {hi, lo}); end
    op = OP_MULT; a = 32'd2; b = 32'd2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    reset = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_in_reset: got busy %b expected 0", busy); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_done: got %0d expected 0", seen); end
  endtask

  task automatic test_random();
    int cyc, bc, ov;
    logic [63:0] res, exp_v;
    logic [1:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 12; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      case (i % 4)
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 20));
        2: y = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
        default: y = $urandom;
      endcase
      issue(o, x, y, 1'b1, model(o, x, y));
      wait_done(cyc, bc, ov, res);
      exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
      checks++; if (res !== exp_v || cyc !== 33) begin
        errors++; $display("FAIL random_%0d op=%0d a=%h b=%h: got %h after %0d cycles expected %h after 33", i, o, x, y, res, cyc, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_back_to_back();
    test_div();
    test_divzero();
    test_flush();
    test_reset_mid();
    test_random();
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
